// File: rtl/simple_run_ctrl.sv
// simple_run_ctrl: run/step/halt sequencer for the 4-phase CPU core plus
// data-memory port arbiter between the core and an external host port.
// The host may only access memory while the core is halted, so the core
// never loses the port mid-instruction.
module simple_run_ctrl #(
    parameter bit START_RUN = 1'b0,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_run,
    input  logic              cmd_step,
    input  logic              cmd_halt,
    input  logic              halt_instr,
    output logic [1:0]        phase,
    output logic              phase_en,
    output logic              busy,
    output logic              hlt_seen,
    output logic [CNT_W-1:0]  instr_count,
    input  logic              cpu_dmem_wren,
    input  logic [ADDR_W-1:0] cpu_dmem_addr,
    input  logic [DATA_W-1:0] cpu_dmem_din,
    input  logic              host_req,
    input  logic              host_wren,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              dmem_wren,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    input  logic [DATA_W-1:0] dmem_dout
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_phase;
    logic               r_halt_pend;   // cmd_halt seen in RUN, waiting for boundary
    logic               r_hlt_pend;    // HLT decoded in phase 2, stop at boundary
    logic               r_hlt_seen;
    logic [CNT_W-1:0]   r_count;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic               w_phase_en;
    logic               w_boundary;
    logic               w_hlt_sample;
    logic               w_accept_cmd;
    logic               w_gnt;

    assign w_phase_en   = (r_state != S_HALT);
    assign w_boundary   = w_phase_en && (r_phase == 2'd3);
    assign w_hlt_sample = w_phase_en && (r_phase == 2'd2) && halt_instr;
    assign w_accept_cmd = (r_state == S_HALT) && (cmd_step || cmd_run);
    assign w_gnt        = host_req && (r_state == S_HALT) && !reset;

    // Next-state logic: commands are only honoured in HALT; RUN and STEP
    // leave only at an instruction boundary.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_HALT: begin
                if (cmd_step)
                    w_state_nxt = S_STEP;
                else if (cmd_run)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_boundary && (r_halt_pend || cmd_halt || r_hlt_pend))
                    w_state_nxt = S_HALT;
            end
            S_STEP: begin
                if (w_boundary)
                    w_state_nxt = S_HALT;
            end
            default: w_state_nxt = S_HALT;
        endcase
    end

    // State, phase counter, halt bookkeeping and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= START_RUN ? S_RUN : S_HALT;
            r_phase     <= '0;
            r_halt_pend <= 1'b0;
            r_hlt_pend  <= 1'b0;
            r_hlt_seen  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_phase_en && (w_state_nxt != S_HALT))
                r_phase <= r_phase + 2'd1;
            else
                r_phase <= '0;

            if ((r_state != S_RUN) || w_boundary)
                r_halt_pend <= 1'b0;
            else if (cmd_halt)
                r_halt_pend <= 1'b1;

            if (w_boundary)
                r_hlt_pend <= 1'b0;
            else if (w_hlt_sample)
                r_hlt_pend <= 1'b1;

            if (w_boundary && r_hlt_pend)
                r_hlt_seen <= 1'b1;
            else if (w_accept_cmd)
                r_hlt_seen <= 1'b0;

            if (w_boundary)
                r_count <= r_count + 1'b1;
        end
    end

    // Host read data register: captured on a granted read, valid one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt && !host_wren;
            if (w_gnt && !host_wren)
                r_rdata <= dmem_dout;
        end
    end

    // Port mux: host when granted; otherwise the core, with writes blocked in HALT.
    always_comb begin
        dmem_wren = 1'b0;
        dmem_addr = cpu_dmem_addr;
        dmem_din  = cpu_dmem_din;
        if (w_gnt) begin
            dmem_wren = host_wren;
            dmem_addr = host_addr;
            dmem_din  = host_wdata;
        end else if (r_state != S_HALT) begin
            dmem_wren = cpu_dmem_wren;
        end
    end

    assign phase       = r_phase;
    assign phase_en    = w_phase_en;
    assign busy        = w_phase_en;
    assign hlt_seen    = r_hlt_seen;
    assign instr_count = r_count;
    assign host_gnt    = w_gnt;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rdata;

endmodule

// File: tb/tb_simple_run_ctrl.sv
// Directed testbench for simple_run_ctrl. Main instance uses defaults; a
// second instance (START_RUN=1, CNT_W=4) covers run-from-reset and counter wrap.
module tb_simple_run_ctrl;

    logic        clk = 1'b0;
    logic        reset, cmd_run, cmd_step, cmd_halt, halt_instr;
    logic [1:0]  phase;
    logic        phase_en, busy, hlt_seen;
    logic [15:0] instr_count;
    logic        cpu_dmem_wren;
    logic [7:0]  cpu_dmem_addr, cpu_dmem_din;
    logic        host_req, host_wren;
    logic [7:0]  host_addr, host_wdata;
    logic        host_gnt, host_rvalid;
    logic [7:0]  host_rdata;
    logic        dmem_wren;
    logic [7:0]  dmem_addr, dmem_din, dmem_dout;
    logic [7:0]  mem [256];

    logic        s_reset, s_cmd_run, s_cmd_step, s_cmd_halt;
    logic [1:0]  s_phase;
    logic        s_phase_en, s_busy, s_hlt_seen, s_gnt, s_rvalid, s_dmem_wren;
    logic [3:0]  s_count;
    logic [7:0]  s_rdata, s_dmem_addr, s_dmem_din;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    simple_run_ctrl dut (
        .clk(clk), .reset(reset), .cmd_run(cmd_run), .cmd_step(cmd_step),
        .cmd_halt(cmd_halt), .halt_instr(halt_instr), .phase(phase),
        .phase_en(phase_en), .busy(busy), .hlt_seen(hlt_seen),
        .instr_count(instr_count), .cpu_dmem_wren(cpu_dmem_wren),
        .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_din(cpu_dmem_din),
        .host_req(host_req), .host_wren(host_wren), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .dmem_wren(dmem_wren), .dmem_addr(dmem_addr),
        .dmem_din(dmem_din), .dmem_dout(dmem_dout)
    );

    simple_run_ctrl #(.START_RUN(1'b1), .CNT_W(4)) dut_s (
        .clk(clk), .reset(s_reset), .cmd_run(s_cmd_run), .cmd_step(s_cmd_step),
        .cmd_halt(s_cmd_halt), .halt_instr(1'b0), .phase(s_phase),
        .phase_en(s_phase_en), .busy(s_busy), .hlt_seen(s_hlt_seen),
        .instr_count(s_count), .cpu_dmem_wren(1'b0),
        .cpu_dmem_addr(8'h00), .cpu_dmem_din(8'h00),
        .host_req(1'b0), .host_wren(1'b0), .host_addr(8'h00),
        .host_wdata(8'h00), .host_gnt(s_gnt), .host_rvalid(s_rvalid),
        .host_rdata(s_rdata), .dmem_wren(s_dmem_wren), .dmem_addr(s_dmem_addr),
        .dmem_din(s_dmem_din), .dmem_dout(8'h00)
    );

    // Data memory model: synchronous write, combinational read.
    always @(posedge clk) if (dmem_wren) mem[dmem_addr] <= dmem_din;
    assign dmem_dout = mem[dmem_addr];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_reset = 1'b1; host_req = 1'b1; host_wren = 1'b0;
        tick();
        n_cmp++; if ({busy, phase_en, phase, hlt_seen, host_rvalid, host_gnt} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctl: got %b want 0000000", {busy, phase_en, phase, hlt_seen, host_rvalid, host_gnt}); end
        n_cmp++; if ({instr_count, host_rdata} !== 24'h0) begin
            n_err++; $display("FAIL reset_cnt_rdata: got %h want 000000", {instr_count, host_rdata}); end
        n_cmp++; if ({s_busy, s_phase_en, s_phase} !== 4'b1100) begin
            n_err++; $display("FAIL start_run_reset: got %b want 1100", {s_busy, s_phase_en, s_phase}); end
        reset = 1'b0; s_reset = 1'b0; host_req = 1'b0;
        #1;
        n_cmp++; if ({busy, phase_en, phase, hlt_seen, host_rvalid, host_gnt, instr_count} !== 23'h0) begin
            n_err++; $display("FAIL post_reset: got %h want 0", {busy, phase_en, phase, hlt_seen, host_rvalid, host_gnt, instr_count}); end
        n_cmp++; if ({s_busy, s_phase, s_count} !== 7'b1_00_0000) begin
            n_err++; $display("FAIL start_run_post: got %b want 1000000", {s_busy, s_phase, s_count}); end
    endtask

    task automatic test_run_halt();
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if ({busy, phase_en, phase} !== {2'b11, 2'(k % 4)} || instr_count !== 16'(k / 4)) begin
                n_err++; $display("FAIL run_seq[%0d]: got %b/%0d want %b/%0d", k, {busy, phase_en, phase}, instr_count, {2'b11, 2'(k % 4)}, k / 4); end
            cmd_halt = (k == 13);
            tick();
        end
        cmd_halt = 1'b0;
        n_cmp++; if ({busy, phase_en, phase} !== 4'b0 || instr_count !== 16'd4) begin
            n_err++; $display("FAIL run_halted: got %b/%0d want 0000/4", {busy, phase_en, phase}, instr_count); end
    endtask

    task automatic test_step();
        for (int s = 0; s < 2; s++) begin
            int n_en;
            n_en = 0;
            cmd_step = 1'b1; tick(); cmd_step = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (phase_en) n_en++;
                if (k < 4) begin
                    n_cmp++; if ({busy, phase_en, phase} !== {2'b11, 2'(k)}) begin
                        n_err++; $display("FAIL step_phase[%0d]: got %b want %b", k, {busy, phase_en, phase}, {2'b11, 2'(k)}); end
                end else if (k == 4) begin
                    n_cmp++; if ({busy, phase_en, phase} !== 4'b0 || instr_count !== 16'(5 + s)) begin
                        n_err++; $display("FAIL step_done: got %b/%0d want 0000/%0d", {busy, phase_en, phase}, instr_count, 5 + s); end
                end
                cmd_halt = (k == 1);
                cmd_run  = (k == 2);
                tick();
            end
            n_cmp++; if (n_en !== 4) begin
                n_err++; $display("FAIL step_en_cycles: got %0d want 4", n_en); end
        end
        n_cmp++; if (busy !== 1'b0 || instr_count !== 16'd6) begin
            n_err++; $display("FAIL step_final: got %b/%0d want 0/6", busy, instr_count); end
    endtask

    task automatic test_hlt();
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 4 || k == 7) begin
                n_cmp++; if ({busy, phase, hlt_seen} !== {1'b1, 2'(k % 4), 1'b0}) begin
                    n_err++; $display("FAIL hlt_run[%0d]: got %b want %b", k, {busy, phase, hlt_seen}, {1'b1, 2'(k % 4), 1'b0}); end
            end
            halt_instr = (k == 1 || k == 6);
            tick();
        end
        halt_instr = 1'b0;
        n_cmp++; if ({busy, phase_en, hlt_seen} !== 3'b001 || instr_count !== 16'd8) begin
            n_err++; $display("FAIL hlt_stop: got %b/%0d want 001/8", {busy, phase_en, hlt_seen}, instr_count); end
        tick();
        n_cmp++; if (hlt_seen !== 1'b1) begin
            n_err++; $display("FAIL hlt_sticky: got %b want 1", hlt_seen); end
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        n_cmp++; if ({busy, phase, hlt_seen} !== 4'b1000) begin
            n_err++; $display("FAIL hlt_clear: got %b want 1000", {busy, phase, hlt_seen}); end
        tick(); tick(); tick();
        n_cmp++; if (phase !== 2'd3) begin
            n_err++; $display("FAIL hlt_ph3: got %0d want 3", phase); end
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        n_cmp++; if ({busy, phase} !== 3'b000 || instr_count !== 16'd9) begin
            n_err++; $display("FAIL halt_at_ph3: got %b/%0d want 000/9", {busy, phase}, instr_count); end
    endtask

    task automatic test_host();
        host_req = 1'b1; host_wren = 1'b1; host_addr = 8'h10; host_wdata = 8'h5A;
        cpu_dmem_wren = 1'b1; cpu_dmem_addr = 8'h33; cpu_dmem_din = 8'hC3;
        #1;
        n_cmp++; if ({host_gnt, dmem_wren, dmem_addr, dmem_din} !== {2'b11, 8'h10, 8'h5A}) begin
            n_err++; $display("FAIL host_wr_grant: got %h want 3105a", {host_gnt, dmem_wren, dmem_addr, dmem_din}); end
        tick(); host_wren = 1'b0; #1;
        n_cmp++; if ({host_rvalid, host_gnt, dmem_wren, dmem_addr} !== {3'b010, 8'h10}) begin
            n_err++; $display("FAIL host_rd_grant: got %h want 210", {host_rvalid, host_gnt, dmem_wren, dmem_addr}); end
        tick(); host_req = 1'b0; #1;
        n_cmp++; if ({host_rvalid, host_rdata} !== {1'b1, 8'h5A}) begin
            n_err++; $display("FAIL host_rdata: got %h want 15a", {host_rvalid, host_rdata}); end
        n_cmp++; if ({host_gnt, dmem_wren, dmem_addr} !== {2'b00, 8'h33}) begin
            n_err++; $display("FAIL halt_cpu_blocked: got %h want 033", {host_gnt, dmem_wren, dmem_addr}); end
        tick();
        n_cmp++; if (host_rvalid !== 1'b0) begin
            n_err++; $display("FAIL rvalid_one_cycle: got %b want 0", host_rvalid); end
        // Host read issued in the same cycle as cmd_run, then held through RUN.
        host_req = 1'b1; host_addr = 8'h10; cmd_run = 1'b1; #1;
        n_cmp++; if ({host_gnt, dmem_wren, dmem_addr} !== {2'b10, 8'h10}) begin
            n_err++; $display("FAIL gnt_with_run: got %h want 210", {host_gnt, dmem_wren, dmem_addr}); end
        tick(); cmd_run = 1'b0;
        n_cmp++; if ({busy, host_gnt, host_rvalid, host_rdata} !== {3'b101, 8'h5A}) begin
            n_err++; $display("FAIL run_owns_port: got %h want 55a", {busy, host_gnt, host_rvalid, host_rdata}); end
        n_cmp++; if ({dmem_wren, dmem_addr, dmem_din} !== {1'b1, 8'h33, 8'hC3}) begin
            n_err++; $display("FAIL cpu_path: got %h want 133c3", {dmem_wren, dmem_addr, dmem_din}); end
        cmd_halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); cmd_halt = 1'b0;
            n_cmp++; if ({busy, host_gnt, host_rvalid} !== 3'b100) begin
                n_err++; $display("FAIL no_gnt_in_run[%0d]: got %b want 100", k, {busy, host_gnt, host_rvalid}); end
        end
        tick(); host_addr = 8'h33; #1;
        n_cmp++; if ({busy, host_gnt} !== 2'b01 || instr_count !== 16'd10) begin
            n_err++; $display("FAIL gnt_after_halt: got %b/%0d want 01/10", {busy, host_gnt}, instr_count); end
        tick(); host_req = 1'b0; cpu_dmem_wren = 1'b0;
        n_cmp++; if ({host_rvalid, host_rdata} !== {1'b1, 8'hC3}) begin
            n_err++; $display("FAIL rd_cpu_data: got %h want 1c3", {host_rvalid, host_rdata}); end
    endtask

    task automatic test_reset_mid();
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        tick();
        n_cmp++; if ({busy, phase} !== 3'b110) begin
            n_err++; $display("FAIL pre_reset_ph2: got %b want 110", {busy, phase}); end
        reset = 1'b1; tick(); reset = 1'b0;
        n_cmp++; if ({busy, phase_en, phase, hlt_seen} !== 5'b0 || instr_count !== 16'd0) begin
            n_err++; $display("FAIL reset_mid: got %b/%0d want 00000/0", {busy, phase_en, phase, hlt_seen}, instr_count); end
        cmd_run = 1'b1; tick(); cmd_run = 1'b0;
        tick(); tick(); tick(); tick();
        n_cmp++; if ({busy, phase} !== 3'b100 || instr_count !== 16'd1) begin
            n_err++; $display("FAIL halt_pend_cleared: got %b/%0d want 100/1", {busy, phase}, instr_count); end
        cmd_halt = 1'b1; tick(); cmd_halt = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if (busy !== 1'b0 || instr_count !== 16'd2) begin
            n_err++; $display("FAIL halt_4cyc: got %b/%0d want 0/2", busy, instr_count); end
        host_req = 1'b1; host_wren = 1'b0; host_addr = 8'h10; reset = 1'b1; #1;
        n_cmp++; if (host_gnt !== 1'b0) begin
            n_err++; $display("FAIL gnt_in_reset: got %b want 0", host_gnt); end
        tick(); reset = 1'b0; host_req = 1'b0;
        n_cmp++; if ({host_rvalid, host_rdata} !== 9'h0) begin
            n_err++; $display("FAIL aborted_read: got %h want 000", {host_rvalid, host_rdata}); end
    endtask

    task automatic test_wrap();
        s_reset = 1'b1; tick(); s_reset = 1'b0;
        n_cmp++; if ({s_busy, s_phase, s_count} !== 7'b1_00_0000) begin
            n_err++; $display("FAIL wrap_start: got %b want 1000000", {s_busy, s_phase, s_count}); end
        for (int k = 0; k < 56; k++) tick();
        n_cmp++; if ({s_busy, s_phase, s_count} !== 7'b1_00_1110) begin
            n_err++; $display("FAIL wrap_c14: got %b want 1001110", {s_busy, s_phase, s_count}); end
        s_cmd_halt = 1'b1; tick(); s_cmd_halt = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({s_busy, s_count} !== 5'b0_1111) begin
            n_err++; $display("FAIL wrap_max: got %b want 01111", {s_busy, s_count}); end
        s_cmd_step = 1'b1; tick(); s_cmd_step = 1'b0;
        tick(); tick(); tick();
        n_cmp++; if ({s_busy, s_phase, s_count} !== 7'b1_11_1111) begin
            n_err++; $display("FAIL wrap_step_ph3: got %b want 1111111", {s_busy, s_phase, s_count}); end
        tick();
        n_cmp++; if ({s_busy, s_phase_en, s_phase, s_count} !== 8'h00) begin
            n_err++; $display("FAIL wrap_zero: got %b want 00000000", {s_busy, s_phase_en, s_phase, s_count}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; s_reset = 1'b1;
        cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; halt_instr = 1'b0;
        cpu_dmem_wren = 1'b0; cpu_dmem_addr = 8'h00; cpu_dmem_din = 8'h00;
        host_req = 1'b0; host_wren = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
        s_cmd_run = 1'b0; s_cmd_step = 1'b0; s_cmd_halt = 1'b0;
        tick();
        test_reset();
        test_run_halt();
        test_step();
        test_hlt();
        test_host();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
